// File: rtl/input_conditioner.sv
// Synchronises and debounces the switch bus and active-low buttons, turning each press into one operand update plus a valid/ack event.
// Strobes appear DEBOUNCE_CYCLES+2 cycles after a raw change and value/event one cycle later; no backpressure: an unacked event is overwritten and flagged in overrun.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] num,
  input  logic       suma,
  input  logic       resta,
  input  logic       evt_ack,
  output logic [3:0] num_q,
  output logic       suma_lvl,
  output logic       resta_lvl,
  output logic       suma_pulse,
  output logic       resta_pulse,
  output logic [7:0] value,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  output logic       overrun
);

  localparam logic [19:0] CNT_LAST = 20'(DEBOUNCE_CYCLES - 1);
  // The word counter only starts once the new word has been seen twice, so it accepts one count earlier.
  localparam logic [19:0] NUM_LAST = 20'(DEBOUNCE_CYCLES - 2);

  logic [1:0]  suma_sync;
  logic [1:0]  resta_sync;
  logic [3:0]  num_s1;
  logic [3:0]  num_s2;
  logic [3:0]  num_prev;
  logic [19:0] suma_cnt;
  logic [19:0] resta_cnt;
  logic [19:0] num_cnt;
  logic        suma_in;
  logic        resta_in;
  logic        any_pulse;

  always_ff @(posedge clk) begin
    if (reset) begin
      suma_sync  <= 2'b11;
      resta_sync <= 2'b11;
      num_s1     <= '0;
      num_s2     <= '0;
      num_prev   <= '0;
    end else begin
      suma_sync  <= {suma_sync[0], suma};
      resta_sync <= {resta_sync[0], resta};
      num_s1     <= num;
      num_s2     <= num_s1;
      num_prev   <= num_s2;
    end
  end

  assign suma_in   = ~suma_sync[1];
  assign resta_in  = ~resta_sync[1];
  assign any_pulse = suma_pulse | resta_pulse;

  always_ff @(posedge clk) begin
    if (reset) begin
      suma_cnt   <= '0;
      suma_lvl   <= 1'b0;
      suma_pulse <= 1'b0;
    end else begin
      suma_pulse <= 1'b0;
      if (suma_in == suma_lvl) begin
        suma_cnt <= '0;
      end else if (suma_cnt == CNT_LAST) begin
        suma_cnt   <= '0;
        suma_lvl   <= suma_in;
        suma_pulse <= suma_in;
      end else begin
        suma_cnt <= suma_cnt + 20'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resta_cnt   <= '0;
      resta_lvl   <= 1'b0;
      resta_pulse <= 1'b0;
    end else begin
      resta_pulse <= 1'b0;
      if (resta_in == resta_lvl) begin
        resta_cnt <= '0;
      end else if (resta_cnt == CNT_LAST) begin
        resta_cnt   <= '0;
        resta_lvl   <= resta_in;
        resta_pulse <= resta_in;
      end else begin
        resta_cnt <= resta_cnt + 20'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      num_cnt <= '0;
      num_q   <= '0;
    end else if (num_s2 == num_q || num_s2 != num_prev) begin
      num_cnt <= '0;
    end else if (num_cnt == NUM_LAST) begin
      num_cnt <= '0;
      num_q   <= num_s2;
    end else begin
      num_cnt <= num_cnt + 20'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (suma_pulse && !resta_pulse) begin
      value <= value + {4'b0, num_q};
    end else if (resta_pulse && !suma_pulse) begin
      value <= value - {4'b0, num_q};
    end
  end

  // A new strobe takes priority over an ack in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      evt_valid <= 1'b0;
      evt_code  <= '0;
      overrun   <= 1'b0;
    end else if (any_pulse) begin
      evt_valid <= 1'b1;
      evt_code  <= {resta_pulse, suma_pulse};
      if (evt_valid && !evt_ack) overrun <= 1'b1;
    end else if (evt_ack) begin
      evt_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner with DEBOUNCE_CYCLES = 4.
module tb_input_conditioner;
  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] num;
  logic       suma;
  logic       resta;
  logic       evt_ack;
  logic [3:0] num_q;
  logic       suma_lvl, resta_lvl, suma_pulse, resta_pulse;
  logic [7:0] value;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] code;
    logic [7:0] value;
    logic       ovr;
  } exp_t;
  exp_t sb[$];
  logic [7:0] mv = 8'd0;

  input_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .num(num), .suma(suma), .resta(resta), .evt_ack(evt_ack),
    .num_q(num_q), .suma_lvl(suma_lvl), .resta_lvl(resta_lvl), .suma_pulse(suma_pulse),
    .resta_pulse(resta_pulse), .value(value), .evt_valid(evt_valid), .evt_code(evt_code),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Presses the selected buttons, waits (bounded) for a strobe, optionally acks in the strobe cycle,
  // and samples the event outputs one cycle after the strobe.
  task automatic stim_press(input logic s, input logic r, input logic ack_with,
                            output int lat, output logic both, output logic extra,
                            output logic [7:0] ov, output logic [1:0] oc,
                            output logic ovl, output logic oovr);
    lat = -1; both = 1'b0; extra = 1'b0; ov = '0; oc = '0; ovl = 1'b0; oovr = 1'b0;
    if (s) suma = 1'b0;
    if (r) resta = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (suma_pulse || resta_pulse) begin
        lat = i;
        both = suma_pulse && resta_pulse;
        break;
      end
    end
    if (lat > 0) begin
      if (ack_with) evt_ack = 1'b1;
      @(negedge clk);
      evt_ack = 1'b0;
      extra = suma_pulse | resta_pulse;
      ov = value; oc = evt_code; ovl = evt_valid; oovr = overrun;
    end
  endtask

  task automatic release_all(output logic seen);
    seen = 1'b0;
    suma = 1'b1;
    resta = 1'b1;
    for (int i = 0; i < 2 * DC + 6; i++) begin
      @(negedge clk);
      if (suma_pulse || resta_pulse) seen = 1'b1;
    end
  endtask

  task automatic do_ack();
    evt_ack = 1'b1;
    @(negedge clk);
    evt_ack = 1'b0;
  endtask

  task automatic set_num(input logic [3:0] n);
    num = n;
    tick(10);
  endtask

  task automatic test_reset();
    int cnt, at;
    exp_t e;
    logic seen;
    reset = 1'b1; suma = 1'b0; resta = 1'b1; num = 4'd0; evt_ack = 1'b0;
    tick(2);
    checks++;
    if ({num_q, suma_lvl, resta_lvl, suma_pulse, resta_pulse} !== 8'd0) begin
      errors++; $display("FAIL reset_levels got %h want 00", {num_q, suma_lvl, resta_lvl, suma_pulse, resta_pulse});
    end
    checks++;
    if ({value, evt_valid, evt_code, overrun} !== 12'd0) begin
      errors++; $display("FAIL reset_event got %h want 000", {value, evt_valid, evt_code, overrun});
    end
    sb.push_back('{code: 2'b01, value: mv, ovr: 1'b0});
    reset = 1'b0;
    cnt = 0; at = -1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (suma_pulse) begin cnt++; if (at < 0) at = i; end
    end
    checks++;
    if (cnt !== 1) begin errors++; $display("FAIL reset_pulse_count got %0d want 1", cnt); end
    checks++;
    if (at !== DC + 2) begin errors++; $display("FAIL reset_pulse_edge got %0d want %0d", at, DC + 2); end
    e = sb.pop_front();
    checks++;
    if ({evt_valid, evt_code, value} !== {1'b1, e.code, e.value}) begin
      errors++; $display("FAIL reset_event_after got %h want %h", {evt_valid, evt_code, value}, {1'b1, e.code, e.value});
    end
    release_all(seen);
    do_ack();
    checks++;
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", evt_valid); end
  endtask

  task automatic test_bounce();
    logic bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      suma = k[0];
      for (int j = 0; j < 2; j++) begin
        @(negedge clk);
        if (suma_lvl || suma_pulse || evt_valid) bad = 1'b1;
      end
    end
    suma = 1'b1;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (suma_lvl || suma_pulse || evt_valid) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL bounce_rejected got %b want 0", bad); end
  endtask

  // Pushes the modelled event, runs the press, and compares everything against the popped entry.
  task automatic press_checked(input string name, input logic s, input logic r, input logic ack_with,
                               input logic [3:0] nq, input logic ovr_exp);
    exp_t e;
    int lat;
    logic both, extra, ovl, oovr, seen;
    logic [7:0] ov;
    logic [1:0] oc;
    if (s && !r) mv = mv + {4'b0, nq};
    else if (r && !s) mv = mv - {4'b0, nq};
    sb.push_back('{code: {r, s}, value: mv, ovr: ovr_exp});
    stim_press(s, r, ack_with, lat, both, extra, ov, oc, ovl, oovr);
    e = sb.pop_front();
    checks++;
    if (lat !== DC + 2) begin errors++; $display("FAIL %s_latency got %0d want %0d", name, lat, DC + 2); end
    checks++;
    if (both !== (s && r)) begin errors++; $display("FAIL %s_both got %b want %b", name, both, s && r); end
    checks++;
    if (extra !== 1'b0) begin errors++; $display("FAIL %s_pulse_width got %b want 0", name, extra); end
    checks++;
    if ({ovl, oc, ov, oovr} !== {1'b1, e.code, e.value, e.ovr}) begin
      errors++; $display("FAIL %s_event got v=%b c=%b val=%h o=%b want v=1 c=%b val=%h o=%b",
                         name, ovl, oc, ov, oovr, e.code, e.value, e.ovr);
    end
    release_all(seen);
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL %s_release_pulse got %b want 0", name, seen); end
  endtask

  task automatic test_addition();
    set_num(4'd5);
    checks++;
    if (num_q !== 4'd5) begin errors++; $display("FAIL add_num_q got %0d want 5", num_q); end
    press_checked("add", 1'b1, 1'b0, 1'b0, 4'd5, 1'b0);
    do_ack();
  endtask

  task automatic test_underflow();
    set_num(4'd2);
    press_checked("sub_to3", 1'b0, 1'b1, 1'b0, 4'd2, 1'b0);
    do_ack();
    checks++;
    if (value !== 8'd3) begin errors++; $display("FAIL sub_value3 got %h want 03", value); end
    set_num(4'd7);
    checks++;
    if (num_q !== 4'd7) begin errors++; $display("FAIL sub_num_q got %0d want 7", num_q); end
    press_checked("wrap", 1'b0, 1'b1, 1'b0, 4'd7, 1'b0);
    checks++;
    if (value !== 8'hFC) begin errors++; $display("FAIL wrap_value got %h want fc", value); end
    do_ack();
  endtask

  task automatic test_overrun();
    press_checked("ovr_first", 1'b1, 1'b0, 1'b0, 4'd7, 1'b0);
    press_checked("ovr_second", 1'b1, 1'b0, 1'b0, 4'd7, 1'b1);
    press_checked("ack_and_new", 1'b0, 1'b1, 1'b1, 4'd7, 1'b1);
    do_ack();
    checks++;
    if ({evt_valid, overrun} !== 2'b01) begin
      errors++; $display("FAIL ovr_after_ack got %b want 01", {evt_valid, overrun});
    end
  endtask

  task automatic test_simultaneous();
    set_num(4'd2);
    press_checked("both", 1'b1, 1'b1, 1'b0, 4'd2, 1'b1);
    do_ack();
    checks++;
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL both_ack got %b want 0", evt_valid); end
    do_ack();
    checks++;
    if ({evt_valid, evt_code, value} !== {1'b0, 2'b11, mv}) begin
      errors++; $display("FAIL idle_ack got %h want %h", {evt_valid, evt_code, value}, {1'b0, 2'b11, mv});
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_addition();
    test_underflow();
    test_overrun();
    test_simultaneous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Input stage ahead of the `cpu` in `fpga`. It synchronises and debounces the board switches (`num`) and the active-low push buttons (`suma`, `resta`). It turns each accepted press into a single event that updates an 8-bit operand register. It also raises a valid/ack event flag, which the CPU input ports consume in place of the raw button levels.

## Interface

- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required before a synchronised input is accepted. Legal range is 2..2^20-1.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high; clears all state at the rising edge of `clk`.
- `num` in 4: raw switch bus.
- `suma` in 1: raw push button, active-low (0 = pressed).
- `resta` in 1: raw push button, active-low.
- `evt_ack` in 1: consumer acknowledge for the pending event.
- `num_q` out 4: debounced switch value.
- `suma_lvl`, `resta_lvl` out 1 each: debounced button state, active-high (1 = pressed).
- `suma_pulse`, `resta_pulse` out 1 each: one-cycle press strobes.
- `value` out 8: operand register, feeds CPU input `e0`.
- `evt_valid` out 1: event pending.
- `evt_code` out 2: bit0 = suma press, bit1 = resta press.
- `overrun` out 1: sticky; a press arrived while `evt_valid` was 1 and no ack occurred that cycle.

## Operation

- **Synchronisers:** each raw input passes through a 2-flop synchroniser. Reset values are: button flops 1 (released), `num` flops 0.
- **Button debounce** (one independent channel per button, 20-bit counter `cnt`):
  - If the synced, inverted level equals the channel's `*_lvl`, `cnt` is set to 0.
  - Otherwise `cnt` increments.
  - When `cnt` equals `DEBOUNCE_CYCLES-1` and the level still differs, `*_lvl` takes the synced level and `cnt` is set to 0.
  - Any glitch shorter than `DEBOUNCE_CYCLES` cycles is discarded.
- **Switch-bus debounce:** `num` is debounced as one 4-bit word with its own counter.
  - The counter is set to 0 whenever the synced word equals `num_q` or differs from the previous cycle's synced word.
  - `num_q` updates after `DEBOUNCE_CYCLES` consecutive cycles of an identical, different word.
- **Press strobe:** `*_pulse` is registered. It is 1 in exactly the cycle in which `*_lvl` first reads 1. Releases produce no strobe.
- **Operand update** at the edge that ends a strobe cycle; all arithmetic is mod 256, with no saturation:
  - `suma_pulse` only: `value <= value + {4'b0, num_q}`.
  - `resta_pulse` only: `value <= value - {4'b0, num_q}`.
  - Both strobes in the same cycle: `value` unchanged, `evt_code <= 2'b11`.
- **Event handshake:**
  - Any strobe sets `evt_valid` and loads `evt_code` at the same edge as the `value` update.
  - `evt_ack` = 1 with `evt_valid` = 1 clears `evt_valid`. `evt_code` holds its last value.
  - A strobe in the same cycle as `evt_ack`: the new event wins. `evt_valid` stays 1, `evt_code` takes the new code, and `overrun` is not set.
  - A strobe while `evt_valid` = 1 and `evt_ack` = 0: `evt_code` is overwritten, `value` still updates, and `overrun <= 1`. `overrun` clears only on `reset`.
  - `evt_ack` while `evt_valid` = 0 is ignored.
- **Reset values:** `num_q` = 0, `*_lvl` = 0, `*_pulse` = 0, `value` = 0, `evt_valid` = 0, `evt_code` = 0, `overrun` = 0, all counters 0.
- **Reset during a debounce:** the count is lost. A button held through `reset` is re-debounced after release and produces one strobe.

## Timing

- Raw change captured at edge 0 → synced value visible after edge 2.
- `*_lvl` and `*_pulse` = 1 after edge 2+`DEBOUNCE_CYCLES`.
- `value` and `evt_valid` update at edge 3+`DEBOUNCE_CYCLES`.
- `num_q` updates after edge 2+`DEBOUNCE_CYCLES`, provided the word was held constant.
- `*_pulse` width is always exactly 1 cycle. The minimum spacing between two strobes of one button is 2·`DEBOUNCE_CYCLES` cycles (press plus release).
- `evt_ack` is sampled at the rising edge. `evt_valid` falls at that same edge.
- No combinational path from any input to any output.

## Test plan

All scenarios use `DEBOUNCE_CYCLES` = 4.

1. **Reset:** assert `reset` for 2 cycles with `suma` = 0 held → all outputs 0. After release, `suma_pulse` is seen exactly once, 6 edges later.
2. **Bounce rejection:** `suma` toggles 0/1 every 2 cycles for 20 cycles, then is held 1 → `suma_lvl`, `suma_pulse` and `evt_valid` never assert.
3. **Addition:** `num` = 4'd5 held 10 cycles, then `suma` pressed and held → `suma_pulse` 1 for exactly 1 cycle, `value` 0→5, `evt_valid` = 1, `evt_code` = 01.
4. **Underflow wrap:** from `value` = 3, `num_q` = 7, press `resta` → `value` = 8'hFC, `evt_code` = 10.
5. **Overrun:** press `suma` with `evt_valid` = 1 and no ack → `overrun` = 1 and `evt_code` = 01. Then assert `evt_ack` with a new `resta` strobe in the same cycle → `evt_valid` stays 1, `evt_code` = 10, `overrun` stays 1.
6. **Simultaneous presses:** press `suma` and `resta` released/pressed on the same edge with `num_q` = 2 → both strobes in the same cycle, `value` unchanged, `evt_code` = 11. Then assert `evt_ack` → `evt_valid` = 0.
